// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS-I core: opcode and funct codes,
// FSM state encoding, ALU operation set and the instruction decode helper.
package mips_pkg;

    // Primary opcodes (ir[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (ir[5:0])
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor,
        AluSlt, AluSltu, AluSll, AluSrl, AluSra, AluLui
    } alu_op_t;

    typedef struct packed {
        logic    legal;    // instruction is in the supported set
        logic    use_imm;  // second ALU operand is the immediate
        logic    zext;     // immediate is zero-extended (logical immediates)
        alu_op_t alu_op;
    } dec_t;

    function automatic dec_t decode(logic [31:0] ir);
        dec_t d;
        d.legal   = 1'b1;
        d.use_imm = 1'b1;
        d.zext    = 1'b0;
        d.alu_op  = AluAdd;
        case (ir[31:26])
            OP_RTYPE: begin
                d.use_imm = 1'b0;
                case (ir[5:0])
                    F_SLL:          d.alu_op = AluSll;
                    F_SRL:          d.alu_op = AluSrl;
                    F_SRA:          d.alu_op = AluSra;
                    F_JR:           d.alu_op = AluAdd;
                    F_ADD, F_ADDU:  d.alu_op = AluAdd;
                    F_SUB, F_SUBU:  d.alu_op = AluSub;
                    F_AND:          d.alu_op = AluAnd;
                    F_OR:           d.alu_op = AluOr;
                    F_XOR:          d.alu_op = AluXor;
                    F_NOR:          d.alu_op = AluNor;
                    F_SLT:          d.alu_op = AluSlt;
                    F_SLTU:         d.alu_op = AluSltu;
                    default:        d.legal  = 1'b0;
                endcase
            end
            OP_J, OP_JAL:                        d.alu_op = AluAdd;
            OP_BEQ, OP_BNE:                      d.use_imm = 1'b0;
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW:     d.alu_op = AluAdd;
            OP_SLTI:                             d.alu_op = AluSlt;
            OP_SLTIU:                            d.alu_op = AluSltu;
            OP_ANDI: begin d.alu_op = AluAnd; d.zext = 1'b1; end
            OP_ORI:  begin d.alu_op = AluOr;  d.zext = 1'b1; end
            OP_XORI: begin d.alu_op = AluXor; d.zext = 1'b1; end
            OP_LUI:                              d.alu_op = AluLui;
            default:                             d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// one asynchronous debug read port. R0 reads as zero and ignores writes.
// Ports: clk, rst (async, active-high, clears all registers), raddr1/rdata1,
// raddr2/rdata2, we/waddr/wdata, dbg_addr/dbg_data.
module mips_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1   = (raddr1 == 5'd0)   ? '0 : regs[raddr1];
    assign rdata2   = (raddr2 == 5'd0)   ? '0 : regs[raddr2];
    assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/mips_mc_core.sv
// Multicycle MIPS-I integer core. One instruction at a time through
// FETCH/DECODE/EXEC/MEM/WB over a single shared memory port with req/ready wait states.
// Ports: clk, rst (async, active-high); memory port mem_req/mem_we/mem_addr/mem_wdata
// out, mem_rdata/mem_ready in; status pc, state, halted; dbg_reg = R[DBG_REG].
module mips_mc_core
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       DBG_REG  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              halted,
    output logic [31:0]       dbg_reg
);

    state_t      st;
    logic [31:0] ir, a_reg, b_reg, alu_out, mdr;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    dec_t        dec;
    logic [31:0] imm, opb, alu_res;
    logic [31:0] rs_data, rt_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pc32, exec_pc;
    logic        is_ctrl, is_mem;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign funct = ir[5:0];
    assign dec   = decode(ir);
    assign imm   = dec.zext ? {16'h0, ir[15:0]} : {{16{ir[15]}}, ir[15:0]};
    assign pc32  = 32'(pc);
    assign state = st;

    assign is_ctrl = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J) || (op == OP_JAL) ||
                     ((op == OP_RTYPE) && (funct == F_JR));
    assign is_mem  = (op == OP_LW) || (op == OP_SW);

    always_comb begin
        opb     = dec.use_imm ? imm : b_reg;
        alu_res = '0;
        case (dec.alu_op)
            AluAdd:  alu_res = a_reg + opb;
            AluSub:  alu_res = a_reg - opb;
            AluAnd:  alu_res = a_reg & opb;
            AluOr:   alu_res = a_reg | opb;
            AluXor:  alu_res = a_reg ^ opb;
            AluNor:  alu_res = ~(a_reg | opb);
            AluSlt:  alu_res = {31'h0, $signed(a_reg) < $signed(opb)};
            AluSltu: alu_res = {31'h0, a_reg < opb};
            AluSll:  alu_res = b_reg << shamt;
            AluSrl:  alu_res = b_reg >> shamt;
            AluSra:  alu_res = $signed(b_reg) >>> shamt;
            AluLui:  alu_res = {ir[15:0], 16'h0};
            default: alu_res = '0;
        endcase
    end

    // pc has already advanced past the instruction, so branch offsets are relative to it.
    always_comb begin
        exec_pc = pc32;
        if (op == OP_BEQ && a_reg == b_reg) begin
            exec_pc = pc32 + {imm[29:0], 2'b00};
        end else if (op == OP_BNE && a_reg != b_reg) begin
            exec_pc = pc32 + {imm[29:0], 2'b00};
        end else if (op == OP_J || op == OP_JAL) begin
            exec_pc = {pc32[31:28], ir[25:0], 2'b00};
        end else if (op == OP_RTYPE && funct == F_JR) begin
            exec_pc = a_reg;
        end
    end

    // jal links in EXEC (pc is inst+4 there); everything else writes back in WB.
    always_comb begin
        rf_we    = (st == StWb) || (st == StExec && op == OP_JAL);
        rf_waddr = (op == OP_RTYPE) ? rd : rt;
        rf_wdata = (op == OP_LW) ? mdr : alu_out;
        if (st == StExec) begin
            rf_waddr = 5'd31;
            rf_wdata = pc32;
        end
    end

    mips_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .raddr1   (rs),
        .rdata1   (rs_data),
        .raddr2   (rt),
        .rdata2   (rt_data),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .dbg_addr (5'(DBG_REG)),
        .dbg_data (dbg_reg)
    );

    // Every transition into FETCH raises mem_req with the new pc so a zero-wait fetch
    // costs one cycle; only the first fetch after reset spends an extra cycle raising it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= StFetch;
            pc        <= RESET_PC;
            ir        <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            halted    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            unique case (st)
                StFetch: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end else if (mem_ready) begin
                        ir      <= mem_rdata;
                        pc      <= pc + ADDR_W'(4);
                        mem_req <= 1'b0;
                        st      <= StDecode;
                    end
                end
                StDecode: begin
                    a_reg <= rs_data;
                    b_reg <= rt_data;
                    if (!dec.legal) begin
                        st     <= StHalt;
                        halted <= 1'b1;
                    end else begin
                        st <= StExec;
                    end
                end
                StExec: begin
                    alu_out <= alu_res;
                    if (is_ctrl) begin
                        pc       <= ADDR_W'(exec_pc);
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= ADDR_W'(exec_pc);
                        st       <= StFetch;
                    end else if (is_mem) begin
                        mem_req   <= 1'b1;
                        mem_we    <= (op == OP_SW);
                        mem_addr  <= ADDR_W'({alu_res[31:2], 2'b00});
                        mem_wdata <= b_reg;
                        st        <= StMem;
                    end else begin
                        st <= StWb;
                    end
                end
                StMem: begin
                    if (mem_ready) begin
                        mem_we <= 1'b0;
                        if (op == OP_LW) begin
                            mdr     <= mem_rdata;
                            mem_req <= 1'b0;
                            st      <= StWb;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= pc;
                            st       <= StFetch;
                        end
                    end
                end
                StWb: begin
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc;
                    st       <= StFetch;
                end
                StHalt: begin
                    st <= StHalt;
                end
                default: begin
                    st <= StFetch;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_core.sv
// Self-checking bench for mips_mc_core: a table of {address, instruction, cycles,
// next pc, expected store} drives both the memory image and the scoreboards for the
// executed-pc sequence and store traffic; hand-written sequences cover reset and halt.
module tb_mips_mc_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, pc;
    logic [2:0]  state;
    logic        halted;
    logic [31:0] dbg_reg;

    mips_mc_core #(
        .ADDR_W   (32),
        .RESET_PC (32'h0),
        .DBG_REG  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .pc        (pc),
        .state     (state),
        .halted    (halted),
        .dbg_reg   (dbg_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        int          cyc;      // expected cycles; 0 marks the halting instruction
        logic [31:0] nxt;      // address executed next
        bit          st_en;
        logic [31:0] st_addr;
        logic [31:0] st_data;
    } vec_t;

    vec_t        prog[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_wa_q[$];
    logic [31:0] exp_wd_q[$];
    logic [31:0] mem [0:255];

    int fetch_wait = 0;
    int data_wait  = 3;       // applies to data accesses below 0x100
    int wcnt = 0, req_len = 0, cyc_cnt = 0, prev_time = 0, prev_idx = 0, halt_req_cnt = 0;
    bit mon_en = 0, have_prev = 0;
    logic [2:0] prev_state = 3'd0;
    int n_checks = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got 0x%08h expected nothing", name, act);
    endtask

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                          logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                          logic [4:0] sh, logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_j(logic [5:0] op, logic [31:0] target);
        return {op, target[27:2]};
    endfunction

    task automatic add_v(input logic [31:0] a, input logic [31:0] ins, input int c,
                         input logic [31:0] n, input bit se, input logic [31:0] sa,
                         input logic [31:0] sd);
        vec_t v;
        v.addr = a; v.instr = ins; v.cyc = c; v.nxt = n;
        v.st_en = se; v.st_addr = sa; v.st_data = sd;
        prog.push_back(v);
    endtask

    task automatic add_s(input logic [31:0] a, input logic [31:0] ins, input int c);
        add_v(a, ins, c, a + 32'd4, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic add_st(input logic [31:0] a, input logic [31:0] ins, input int c,
                          input logic [31:0] sa, input logic [31:0] sd);
        add_v(a, ins, c, a + 32'd4, 1'b1, sa, sd);
    endtask

    function automatic int find(logic [31:0] a);
        foreach (prog[i]) if (prog[i].addr == a) return i;
        return -1;
    endfunction

    // Memory model and monitors, sampled 1 time unit after each rising edge.
    initial begin
        int lim;
        logic [31:0] ia;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc_cnt++;
            if (mem_req) begin
                lim = (state == 3'd3 && mem_addr < 32'h100) ? data_wait :
                      (state == 3'd0) ? fetch_wait : 0;
                if (wcnt >= lim) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr[9:2]];
                    if (mon_en && state == 3'd3) begin
                        check("mem_req_hold", 32'(req_len + 1),
                              (mem_addr < 32'h100) ? 32'(data_wait + 1) : 32'd1);
                        if (mem_we) begin
                            if (exp_wa_q.size() == 0) begin
                                fail_now("unexpected_store", mem_addr);
                            end else begin
                                check("store_addr", mem_addr, exp_wa_q.pop_front());
                                check("store_data", mem_wdata, exp_wd_q.pop_front());
                            end
                        end
                    end
                    if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
                    wcnt    = 0;
                    req_len = 0;
                end else begin
                    mem_ready = 1'b0;
                    wcnt++;
                    if (state == 3'd3) req_len++;
                end
            end else begin
                mem_ready = 1'b0;
                wcnt      = 0;
                req_len   = 0;
            end

            if (mon_en && state == 3'd1 && prev_state != 3'd1) begin
                ia = pc - 32'd4;
                if (exp_pc_q.size() == 0) fail_now("exec_extra", ia);
                else check("exec_pc", ia, exp_pc_q.pop_front());
                if (have_prev) check("cycles", 32'(cyc_cnt - prev_time), 32'(prog[prev_idx].cyc));
                prev_idx  = find(ia);
                have_prev = (prev_idx >= 0);
                prev_time = cyc_cnt;
            end
            if (mon_en && halted && mem_req) halt_req_cnt++;
            prev_state = state;
        end
    end

    initial begin
        int idx;
        logic [31:0] a;

        // Program table: memory order; skipped entries carry stores that must never appear.
        add_s (32'h00, enc_i(6'h08, 0, 1, 16'h0005), 4);
        add_s (32'h04, enc_i(6'h08, 0, 2, 16'hFFFD), 4);
        add_s (32'h08, enc_r(1, 2, 3, 0, 6'h20), 4);
        add_s (32'h0C, enc_r(2, 1, 4, 0, 6'h22), 4);
        add_st(32'h10, enc_i(6'h2B, 0, 3, 16'h0100), 4, 32'h100, 32'h2);
        add_st(32'h14, enc_i(6'h2B, 0, 4, 16'h0104), 4, 32'h104, 32'hFFFF_FFF8);
        add_st(32'h18, enc_i(6'h2B, 0, 3, 16'h0008), 7, 32'h008, 32'h2);
        add_s (32'h1C, enc_i(6'h23, 0, 5, 16'h0008), 8);
        add_st(32'h20, enc_i(6'h2B, 0, 5, 16'h0108), 4, 32'h108, 32'h2);
        add_v (32'h24, enc_i(6'h04, 1, 1, 16'h0002), 3, 32'h30, 1'b0, 32'h0, 32'h0);
        add_st(32'h28, enc_i(6'h2B, 0, 1, 16'h010C), 4, 32'h10C, 32'h5);
        add_st(32'h2C, enc_i(6'h2B, 0, 1, 16'h010C), 4, 32'h10C, 32'h5);
        add_v (32'h30, enc_i(6'h04, 1, 2, 16'h0005), 3, 32'h34, 1'b0, 32'h0, 32'h0);
        add_v (32'h34, enc_i(6'h05, 1, 2, 16'h0001), 3, 32'h3C, 1'b0, 32'h0, 32'h0);
        add_st(32'h38, enc_i(6'h2B, 0, 0, 16'h010C), 4, 32'h10C, 32'h0);
        add_v (32'h3C, enc_j(6'h03, 32'hC0), 3, 32'hC0, 1'b0, 32'h0, 32'h0);
        add_st(32'h40, enc_i(6'h2B, 0, 31, 16'h0110), 4, 32'h110, 32'h40);
        add_s (32'h44, enc_i(6'h08, 0, 1, 16'hFFFF), 4);
        add_s (32'h48, enc_i(6'h08, 0, 2, 16'h0001), 4);
        add_s (32'h4C, enc_r(1, 2, 6, 0, 6'h2A), 4);
        add_s (32'h50, enc_r(1, 2, 7, 0, 6'h2B), 4);
        add_st(32'h54, enc_i(6'h2B, 0, 6, 16'h0118), 4, 32'h118, 32'h1);
        add_st(32'h58, enc_i(6'h2B, 0, 7, 16'h011C), 4, 32'h11C, 32'h0);
        add_s (32'h5C, enc_i(6'h0F, 0, 8, 16'h1234), 4);
        add_st(32'h60, enc_i(6'h2B, 0, 8, 16'h0120), 4, 32'h120, 32'h1234_0000);
        add_s (32'h64, enc_i(6'h08, 0, 9, 16'hFFF8), 4);
        add_s (32'h68, enc_r(0, 9, 10, 2, 6'h03), 4);
        add_st(32'h6C, enc_i(6'h2B, 0, 10, 16'h0124), 4, 32'h124, 32'hFFFF_FFFE);
        add_s (32'h70, enc_i(6'h0D, 0, 11, 16'h8000), 4);
        add_st(32'h74, enc_i(6'h2B, 0, 11, 16'h0128), 4, 32'h128, 32'h0000_8000);
        add_s (32'h78, enc_i(6'h08, 0, 0, 16'h0007), 4);
        add_st(32'h7C, enc_i(6'h2B, 0, 0, 16'h012C), 4, 32'h12C, 32'h0);
        add_s (32'h80, enc_i(6'h0E, 11, 12, 16'hFFFF), 4);
        add_st(32'h84, enc_i(6'h2B, 0, 12, 16'h0130), 4, 32'h130, 32'h0000_7FFF);
        add_s (32'h88, enc_r(0, 0, 13, 0, 6'h27), 4);
        add_s (32'h8C, enc_r(0, 13, 14, 28, 6'h02), 4);
        add_st(32'h90, enc_i(6'h2B, 0, 14, 16'h0134), 4, 32'h134, 32'hF);
        add_s (32'h94, enc_i(6'h0A, 1, 15, 16'h0000), 4);
        add_st(32'h98, enc_i(6'h2B, 0, 15, 16'h0138), 4, 32'h138, 32'h1);
        add_v (32'h9C, 32'hFC00_0000, 0, 32'h0, 1'b0, 32'h0, 32'h0);
        add_st(32'hC0, enc_i(6'h2B, 0, 1, 16'h0114), 4, 32'h114, 32'h5);
        add_v (32'hC4, enc_r(31, 0, 0, 0, 6'h08), 3, 32'h40, 1'b0, 32'h0, 32'h0);

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        foreach (prog[i]) mem[prog[i].addr[9:2]] = prog[i].instr;

        // Walk the expected control flow, filling the pc and store scoreboards.
        a = 32'h0;
        for (int k = 0; k < 100; k++) begin
            idx = find(a);
            if (idx < 0) break;
            exp_pc_q.push_back(a);
            if (prog[idx].st_en) begin
                exp_wa_q.push_back(prog[idx].st_addr);
                exp_wd_q.push_back(prog[idx].st_data);
            end
            if (prog[idx].cyc == 0) break;
            a = prog[idx].nxt;
        end

        // Reset state, then an async reset in the middle of a stalled fetch.
        fetch_wait = 1000;
        repeat (2) @(posedge clk);
        #2;
        check("reset_state", 32'(state), 32'd0);
        check("reset_pc", pc, 32'h0);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_mem_req", 32'(mem_req), 32'd0);
        check("reset_dbg_reg", dbg_reg, 32'h0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("fetch_req_pending", 32'(mem_req), 32'd1);
        check("fetch_not_ready", 32'(mem_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("rst_drops_req", 32'(mem_req), 32'd0);
        check("rst_mid_pc", pc, 32'h0);
        check("rst_mid_state", 32'(state), 32'd0);
        fetch_wait = 0;
        mon_en     = 1'b1;
        @(negedge clk) rst = 1'b0;

        // Run the program until the illegal opcode halts the core.
        for (int i = 0; i < 3000 && !halted; i++) @(posedge clk);
        if (!halted) fail_now("halt_timeout", pc);
        repeat (20) @(posedge clk);
        #2;
        check("halted", 32'(halted), 32'd1);
        check("halt_state", 32'(state), 32'd5);
        check("halt_pc", pc, 32'hA0);
        check("halt_no_req", 32'(halt_req_cnt), 32'd0);
        check("dbg_reg_r1", dbg_reg, 32'hFFFF_FFFF);
        check("exec_left", 32'(exp_pc_q.size()), 32'd0);
        check("stores_left", 32'(exp_wa_q.size()), 32'd0);

        // Reset leaves HALT.
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_clears_halted", 32'(halted), 32'd0);
        check("rst_clears_state", 32'(state), 32'd0);
        check("rst_clears_dbg", dbg_reg, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
